// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the CNN accelerator layer sequencer.
//   - op codes carried in the top two bits of each layer descriptor
//   - scheduler FSM state encoding (also exported on the debug port)
//   - descriptor field layout helpers; the layout is
//       {op[1:0], step[2:0], dr, dc, di, dr_out, dc_out, di_out}
//     with di_out in the least-significant memaddrbit bits.
package cnn_pkg;

  localparam logic [1:0] OP_NONE = 2'd0;  // reserved, treated as a bad descriptor
  localparam logic [1:0] OP_CONV = 2'd1;
  localparam logic [1:0] OP_POOL = 2'd2;
  localparam logic [1:0] OP_FC   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FIRE   = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // Dimension field slots, counted in units of memaddrbit from the LSB.
  localparam int FLD_DI_OUT = 0;
  localparam int FLD_DC_OUT = 1;
  localparam int FLD_DR_OUT = 2;
  localparam int FLD_DI     = 3;
  localparam int FLD_DC     = 4;
  localparam int FLD_DR     = 5;

  function automatic int desc_w(input int mab);
    return 6 * mab + 5;
  endfunction

  function automatic int off_step(input int mab);
    return 6 * mab;
  endfunction

  function automatic int off_op(input int mab);
    return 6 * mab + 3;
  endfunction

  // Engine bit position for an op code: {fc,pool,conv}. OP_NONE maps to no engine.
  function automatic logic [2:0] op_onehot(input logic [1:0] op);
    logic [2:0] oh;
    oh = 3'b000;
    case (op)
      OP_CONV: oh = 3'b001;
      OP_POOL: oh = 3'b010;
      OP_FC:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/layer_scheduler_if.sv
// layer_scheduler_if: bus between the layer scheduler and the three compute engines.
//   eng_enable  scheduler -> engines  one-hot start pulse {fc,pool,conv}
//   eng_done    engines -> scheduler  one-hot completion pulse {fc,pool,conv}
//   dr,dc,di / dr_out,dc_out,di_out   layer input/output dimensions
//   step        layer stride
//   inaddr,outaddr                    read/write base addresses in the shared RAM
//   mem_sel     shared RAM owner: 0 none, 1 conv, 2 pool, 3 fc
//
// Handshake: there is no valid/ready pair on this bus. A transfer is a single-cycle
// eng_enable pulse on one bit; the addressed engine later answers with a single-cycle
// pulse on the same bit of eng_done, at least one cycle after the enable. The
// dimension/address/mem_sel fields are held constant from the enable until that done.
interface layer_scheduler_if #(
  parameter int memaddrbit = 14
);
  logic [2:0]            eng_enable;
  logic [2:0]            eng_done;
  logic [memaddrbit-1:0] dr;
  logic [memaddrbit-1:0] dc;
  logic [memaddrbit-1:0] di;
  logic [memaddrbit-1:0] dr_out;
  logic [memaddrbit-1:0] dc_out;
  logic [memaddrbit-1:0] di_out;
  logic [2:0]            step;
  logic [memaddrbit-1:0] inaddr;
  logic [memaddrbit-1:0] outaddr;
  logic [1:0]            mem_sel;

  modport master (
    output eng_enable, dr, dc, di, dr_out, dc_out, di_out, step, inaddr, outaddr, mem_sel,
    input  eng_done
  );

  modport slave (
    input  eng_enable, dr, dc, di, dr_out, dc_out, di_out, step, inaddr, outaddr, mem_sel,
    output eng_done
  );
endinterface

// File: rtl/layer_desc_ram.sv
// layer_desc_ram: layer descriptor table, 2**ADDR_W entries of DATA_W bits.
// Synchronous write, asynchronous read; contents are not reset.
//   clk    clock
//   we     write strobe
//   waddr  write index
//   wdata  descriptor to store
//   raddr  read index
//   rdata  descriptor at raddr (combinational)
module layer_desc_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 89
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/layer_scheduler.sv
// layer_scheduler: top-level sequencer of the CNN accelerator.
// Walks a programmable descriptor table (conv / max pooling / fc). For each layer it
// presents dimensions, stride and ping-pong base addresses, hands the shared data RAM
// to the layer's engine, pulses that engine's enable and waits for its done pulse.
// A watchdog moves the sequencer to a sticky ERROR state if an engine never answers.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         run request, honoured only in IDLE
//   num_layers    number of layers to run (1..2**LAYER_BITS); 0 is ignored
//   cfg_we/addr/data  descriptor table write port, honoured only in IDLE
//   eng           engine bus (enable/done, dimensions, addresses, mem_sel)
//   busy          high whenever not IDLE
//   layer_idx     index of the current layer
//   all_done      one-cycle pulse after the last layer completes
//   timeout_err   sticky error flag (watchdog expiry or reserved op code)
//   dbg_state     current FSM state
module layer_scheduler
  import cnn_pkg::*;
#(
  parameter int memaddrbit = 14,
  parameter int LAYER_BITS = 4,
  parameter int IN_BASE    = 0,
  parameter int BUF_A      = 4096,
  parameter int BUF_B      = 8192,
  parameter int TIMEOUT    = 2**20,
  localparam int DESC_W    = desc_w(memaddrbit)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LAYER_BITS:0]   num_layers,
  input  logic                  cfg_we,
  input  logic [LAYER_BITS-1:0] cfg_addr,
  input  logic [DESC_W-1:0]     cfg_data,
  layer_scheduler_if.master     eng,
  output logic                  busy,
  output logic [LAYER_BITS-1:0] layer_idx,
  output logic                  all_done,
  output logic                  timeout_err,
  output state_t                dbg_state
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]       WD_MAX    = WD_W'(TIMEOUT - 1);
  localparam logic [memaddrbit-1:0] IN_BASE_V = memaddrbit'(IN_BASE);
  localparam logic [memaddrbit-1:0] BUF_A_V   = memaddrbit'(BUF_A);
  localparam logic [memaddrbit-1:0] BUF_B_V   = memaddrbit'(BUF_B);

  state_t                state_q, state_d;
  logic [LAYER_BITS-1:0] idx_q, idx_d;
  logic [LAYER_BITS:0]   num_q;
  logic [1:0]            op_q;
  logic [WD_W-1:0]       wd_q;
  logic                  err_q;

  logic [memaddrbit-1:0] dr_q, dc_q, di_q, dr_out_q, dc_out_q, di_out_q;
  logic [memaddrbit-1:0] inaddr_q, outaddr_q;
  logic [2:0]            step_q;
  logic [1:0]            mem_sel_q;

  logic [DESC_W-1:0]     desc_rd;
  logic [memaddrbit-1:0] inaddr_nx, outaddr_nx;
  logic                  done_hit;
  logic                  last_layer;
  logic                  cfg_wr;

  // Table writes are only allowed while idle so a running sequence sees a frozen table.
  assign cfg_wr = cfg_we && (state_q == S_IDLE);

  // The table is read at the index the FSM is about to use, so the descriptor can be
  // registered on the same edge that enters LOAD.
  layer_desc_ram #(
    .ADDR_W (LAYER_BITS),
    .DATA_W (DESC_W)
  ) u_desc_ram (
    .clk   (clk),
    .we    (cfg_wr),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_d),
    .rdata (desc_rd)
  );

  // Ping-pong: layer 0 reads the network input; odd layers read A and write B,
  // even layers read B (or the input) and write A.
  always_comb begin
    inaddr_nx  = IN_BASE_V;
    outaddr_nx = BUF_A_V;
    if (idx_d != '0) begin
      inaddr_nx = idx_d[0] ? BUF_A_V : BUF_B_V;
    end
    if (idx_d[0]) begin
      outaddr_nx = BUF_B_V;
    end
  end

  // Only the done bit of the engine owning the current layer counts.
  assign done_hit   = |(eng.eng_done & op_onehot(op_q));
  assign last_layer = ({1'b0, idx_q} == (num_q - 1'b1));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start && (num_layers != '0)) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        state_d = (op_q == OP_NONE) ? S_ERROR : S_FIRE;
      end
      S_FIRE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done on the final watchdog cycle still wins over the timeout.
        if (done_hit) begin
          state_d = last_layer ? S_FINISH : S_NEXT;
        end else if (wd_q == WD_MAX) begin
          state_d = S_ERROR;
        end
      end
      S_NEXT: begin
        idx_d   = idx_q + 1'b1;
        state_d = S_LOAD;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register, layer index and run bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if ((state_q == S_IDLE) && (state_d == S_LOAD)) begin
        num_q <= num_layers;
        err_q <= 1'b0;
      end
      if (state_q == S_FIRE) begin
        wd_q <= '0;
      end else if (state_q == S_WAIT) begin
        wd_q <= wd_q + 1'b1;
      end
      if (state_d == S_ERROR) begin
        err_q <= 1'b1;
      end
    end
  end

  // Layer parameters: captured on entry to LOAD and held until the next LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_NONE;
      dr_q      <= '0;
      dc_q      <= '0;
      di_q      <= '0;
      dr_out_q  <= '0;
      dc_out_q  <= '0;
      di_out_q  <= '0;
      step_q    <= '0;
      inaddr_q  <= '0;
      outaddr_q <= '0;
      mem_sel_q <= '0;
    end else begin
      if (state_d == S_LOAD) begin
        op_q      <= desc_rd[off_op(memaddrbit) +: 2];
        step_q    <= desc_rd[off_step(memaddrbit) +: 3];
        dr_q      <= desc_rd[FLD_DR     * memaddrbit +: memaddrbit];
        dc_q      <= desc_rd[FLD_DC     * memaddrbit +: memaddrbit];
        di_q      <= desc_rd[FLD_DI     * memaddrbit +: memaddrbit];
        dr_out_q  <= desc_rd[FLD_DR_OUT * memaddrbit +: memaddrbit];
        dc_out_q  <= desc_rd[FLD_DC_OUT * memaddrbit +: memaddrbit];
        di_out_q  <= desc_rd[FLD_DI_OUT * memaddrbit +: memaddrbit];
        inaddr_q  <= inaddr_nx;
        outaddr_q <= outaddr_nx;
        // mem_sel encoding equals the op code.
        mem_sel_q <= desc_rd[off_op(memaddrbit) +: 2];
      end
      // Release the shared RAM as soon as the run ends, normally or not.
      if ((state_d == S_FINISH) || (state_d == S_ERROR)) begin
        mem_sel_q <= '0;
      end
    end
  end

  assign eng.eng_enable = (state_q == S_FIRE) ? op_onehot(op_q) : 3'b000;
  assign eng.dr         = dr_q;
  assign eng.dc         = dc_q;
  assign eng.di         = di_q;
  assign eng.dr_out     = dr_out_q;
  assign eng.dc_out     = dc_out_q;
  assign eng.di_out     = di_out_q;
  assign eng.step       = step_q;
  assign eng.inaddr     = inaddr_q;
  assign eng.outaddr    = outaddr_q;
  assign eng.mem_sel    = mem_sel_q;

  assign busy        = (state_q != S_IDLE);
  assign layer_idx   = idx_q;
  assign all_done    = (state_q == S_FINISH);
  assign timeout_err = err_q;
  assign dbg_state   = state_q;

endmodule
